// File: rtl/ntt_pkg.sv
// Shared constants, FSM state type and constant helper functions for the NTT blocks.
package ntt_pkg;

  localparam int N = 17;
  localparam int D = 16;
  localparam longint unsigned Q = 65537;
  localparam longint unsigned W = 4;
  localparam int LOGD = $clog2(D);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Twiddle table entry k: w^k mod q, evaluated at elaboration for k = 0..D/2-1.
  function automatic longint unsigned twiddle(input int k, input longint unsigned w,
                                              input longint unsigned q);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < k; i++) r = (r * w) % q;
    return r;
  endfunction

  // Reverse the low 'bits' bits of x; used for the load permutation.
  function automatic int bit_rev(input int x, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((x >> i) & 1);
    return r;
  endfunction

endpackage

// File: rtl/ntt_seq_if.sv
// Vector-in / vector-out valid-ready handshake bundle for the NTT.
interface ntt_seq_if #(
  parameter int N = 17,
  parameter int D = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [D*N-1:0] a;
  logic           out_valid;
  logic           out_ready;
  logic [D*N-1:0] b;

  modport master (output in_valid, a, out_ready, input in_ready, out_valid, b);
  modport slave  (input in_valid, a, out_ready, output in_ready, out_valid, b);
endinterface

// File: rtl/ntt_butterfly.sv
// Combinational radix-2 butterfly: u' = u + t*v, v' = u - t*v, both mod Q.
module ntt_butterfly #(
  parameter int              N = 17,
  parameter longint unsigned Q = 65537
) (
  input  logic [N-1:0] u,
  input  logic [N-1:0] v,
  input  logic [N-1:0] t,
  output logic [N-1:0] u_out,
  output logic [N-1:0] v_out
);
  logic [2*N-1:0] prod;
  logic [N-1:0]   tv;
  logic [N:0]     sum;
  logic [N:0]     diff;

  // Full-width product before any reduction.
  assign prod = {{N{1'b0}}, t} * {{N{1'b0}}, v};

  generate
    if (Q == 65537) begin : g_fermat
      // 2^16 == -1 mod Q, so p = hi*2^16 + lo reduces to lo - hi (hi <= 2^16 for reduced inputs).
      logic [N:0] lo;
      logic [N:0] hi;
      logic [N:0] dd;
      assign lo = (N+1)'(prod[15:0]);
      assign hi = (N+1)'(prod >> 16);
      assign dd = lo - hi;
      assign tv = (hi > lo) ? N'(dd + (N+1)'(Q)) : N'(dd);
    end else begin : g_generic
      assign tv = N'(prod % (2*N)'(Q));
    end
  endgenerate

  // Add/subtract with a single conditional correction keeps results in [0, Q-1].
  always_comb begin
    sum   = {1'b0, u} + {1'b0, tv};
    diff  = {1'b0, u} - {1'b0, tv};
    u_out = (sum >= (N+1)'(Q)) ? N'(sum - (N+1)'(Q)) : N'(sum);
    v_out = (u < tv) ? N'(diff + (N+1)'(Q)) : N'(diff);
  end

endmodule

// File: rtl/ntt_seq.sv
// Sequential in-place NTT: one DIT butterfly per cycle over a bit-reversed register file.
module ntt_seq #(
  parameter int              N = ntt_pkg::N,
  parameter int              D = ntt_pkg::D,
  parameter longint unsigned Q = ntt_pkg::Q,
  parameter longint unsigned W = ntt_pkg::W
) (
  input  logic     clk,
  input  logic     rst_n,
  ntt_seq_if.slave bus
);
  import ntt_pkg::*;

  localparam int LG   = $clog2(D);
  localparam int HALF = D / 2;

  state_e         state_reg, state_next;
  logic [LG-1:0]  stage_reg, bf_reg;
  logic [N-1:0]   mem_reg   [D];
  logic [N-1:0]   tw_tab    [HALF];
  logic [N-1:0]   lane_load [D];
  logic           accept, last_bf;
  logic [LG-1:0]  mask, grp, top_idx, bot_idx;
  logic [LG-2:0]  tw_idx;
  logic [N-1:0]   u_out, v_out;
  logic [D*N-1:0] b_flat;

  // Constant twiddles W^k and the reduced, bit-reversed load image.
  for (genvar gi = 0; gi < HALF; gi++) begin : g_tw
    localparam logic [N-1:0] TWV = N'(twiddle(gi, W, Q));
    assign tw_tab[gi] = TWV;
  end

  for (genvar gi = 0; gi < D; gi++) begin : g_load
    localparam int SRC = bit_rev(gi, LG);
    logic [N-1:0] lane;
    assign lane          = bus.a[N*SRC +: N];
    assign lane_load[gi] = ({1'b0, lane} >= (N+1)'(Q)) ? N'(lane - N'(Q)) : lane;
  end

  assign accept    = bus.in_valid && (state_reg == IDLE);
  assign last_bf   = (stage_reg == LG'(LG - 1)) && (bf_reg == LG'(HALF - 1));
  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.b         = b_flat;

  // Butterfly addressing: group base, offset within the half-span, and twiddle stride.
  always_comb begin
    mask    = LG'((1 << stage_reg) - 1);
    grp     = bf_reg >> stage_reg;
    top_idx = (grp << (stage_reg + 1'b1)) | (bf_reg & mask);
    bot_idx = top_idx | LG'(1 << stage_reg);
    tw_idx  = (LG-1)'((bf_reg & mask) << (LG - 1 - int'(stage_reg)));
  end

  ntt_butterfly #(.N(N), .Q(Q)) u_bfly (
    .u     (mem_reg[top_idx]),
    .v     (mem_reg[bot_idx]),
    .t     (tw_tab[tw_idx]),
    .u_out (u_out),
    .v_out (v_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: accept, last butterfly, output handshake.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_bf) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage and butterfly counters walk (D/2)*log2(D) butterflies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= '0;
      bf_reg    <= '0;
    end else if (accept) begin
      stage_reg <= '0;
      bf_reg    <= '0;
    end else if (state_reg == RUN) begin
      if (bf_reg == LG'(HALF - 1)) begin
        bf_reg    <= '0;
        stage_reg <= last_bf ? '0 : stage_reg + 1'b1;
      end else begin
        bf_reg <= bf_reg + 1'b1;
      end
    end
  end

  // Register file: cleared on reset, loaded on accept, updated in place in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) mem_reg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < D; i++) mem_reg[i] <= lane_load[i];
    end else if (state_reg == RUN) begin
      mem_reg[top_idx] <= u_out;
      mem_reg[bot_idx] <= v_out;
    end
  end

  // Output vector is the register file in natural order.
  always_comb begin
    b_flat = '0;
    for (int i = 0; i < D; i++) b_flat[N*i +: N] = mem_reg[i];
  end

endmodule

// File: tb/tb_ntt_seq.sv
// Self-checking bench for ntt_seq against a direct O(D^2) transform model.
module tb_ntt_seq;
  localparam int              N  = 17;
  localparam int              D  = 16;
  localparam longint unsigned Q  = 65537;
  localparam longint unsigned W  = 4;
  localparam int              VW = D * N;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  ntt_seq_if #(.N(N), .D(D)) bus ();
  ntt_seq #(.N(N), .D(D), .Q(Q), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned pw(input longint unsigned base, input int e);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * base) % Q;
    return r;
  endfunction

  // b[k] = sum_j a[j] * W^(j*k) mod Q, inputs taken mod Q.
  function automatic logic [VW-1:0] ref_ntt(input logic [VW-1:0] x);
    longint unsigned av [D];
    longint unsigned acc;
    logic [VW-1:0]   r;
    r = '0;
    for (int j = 0; j < D; j++) av[j] = longint'(x[N*j +: N]) % Q;
    for (int k = 0; k < D; k++) begin
      acc = 0;
      for (int j = 0; j < D; j++) acc = (acc + av[j] * pw(W, j * k)) % Q;
      r[N*k +: N] = N'(acc);
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int j = 0; j < D; j++) r[N*j +: N] = N'($urandom_range(0, (1 << N) - 1));
    return r;
  endfunction

  task automatic transact(input string tag, input logic [VW-1:0] vec, input int stall,
                          output logic [VW-1:0] got);
    logic [VW-1:0] exp;
    int lat;
    exp = ref_ntt(vec);
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a        = vec;
    @(posedge clk); #1;
    bus.a = rand_vec();  // in_valid stays high with junk: must be ignored
    chk({tag, "_in_ready_busy"}, 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd32);
    got = bus.b;
    chkv({tag, "_b"}, got, exp);
    for (int c = 0; c < stall; c++) begin
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_stall_in_ready"}, 64'(bus.in_ready), 64'd0);
      chkv({tag, "_stall_b"}, bus.b, exp);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk({tag, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_valid_after"}, 64'(bus.out_valid), 64'd0);
    $display("txn %s stall=%0d latency=%0d b0=%0d", tag, stall, lat, got[N-1:0]);
  endtask

  initial begin
    logic [VW-1:0] v, got, e;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chkv("rst_b_zero", bus.b, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Impulse at lane 0 -> all ones
    v = '0; v[0 +: N] = N'(1);
    transact("impulse0", v, 0, got);
    e = '0;
    for (int k = 0; k < D; k++) e[N*k +: N] = N'(1);
    chkv("impulse0_const", got, e);

    // All ones -> b0 = 16, rest 0
    v = e;
    transact("all_ones", v, 0, got);
    e = '0; e[0 +: N] = N'(16);
    chkv("all_ones_const", got, e);

    // Impulse at lane 1 -> powers of W
    v = '0; v[N +: N] = N'(1);
    transact("impulse1", v, 0, got);
    chk("impulse1_b2", 64'(got[N*2 +: N]), 64'd16);
    chk("impulse1_b8", 64'(got[N*8 +: N]), 64'd65536);
    chk("impulse1_b15", 64'(got[N*15 +: N]), 64'd49153);

    // Unreduced input lane
    v = '0; v[0 +: N] = N'(65538);
    transact("unreduced", v, 0, got);
    e = '0;
    for (int k = 0; k < D; k++) e[N*k +: N] = N'(1);
    chkv("unreduced_const", got, e);

    // Random vectors, including lanes >= Q
    for (int r = 0; r < 6; r++) transact($sformatf("rand%0d", r), rand_vec(), 0, got);

    // Back-pressure: out_ready low for 10 cycles in DONE
    transact("stall", rand_vec(), 10, got);

    // Reset pulse in the middle of RUN
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = rand_vec();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chkv("midrst_b_zero", bus.b, '0);
    $display("txn midrun_reset in_ready=%0d out_valid=%0d", bus.in_ready, bus.out_valid);
    @(negedge clk);
    rst_n = 1'b1;
    v = '0;
    for (int k = 0; k < D; k++) v[N*k +: N] = N'(1);
    transact("post_rst", v, 0, got);
    e = '0; e[0 +: N] = N'(16);
    chkv("post_rst_const", got, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ntt_seq.md
NTT_SEQ -- requirements
Module: ntt_seq

Interface
REQ-001 SHALL have parameter N, default 17: lane width in bits.
REQ-002 SHALL have parameter D, default 16: transform length in lanes, a power of two.
REQ-003 SHALL have parameter Q, default 65537: prime modulus.
REQ-004 SHALL have parameter W, default 4: primitive D-th root of unity mod Q.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1 bit: a holds a vector.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a vector.
REQ-009 SHALL have port a, input, D*N bits: lane j at a[N*(j+1)-1:N*j].
REQ-010 SHALL have port out_valid, output, 1 bit: b holds a result.
REQ-011 SHALL have port out_ready, input, 1 bit: sink accepts b.
REQ-012 SHALL have port b, output, D*N bits: lane k at b[N*(k+1)-1:N*k].

Function
REQ-013 SHALL compute the forward NTT: b[k] = sum over j of a[j]*W^(j*k) mod Q, natural output order; no 1/D scaling.
REQ-014 SHALL use states IDLE, RUN and DONE; IDLE goes to RUN on accept, RUN goes to DONE after the last butterfly, DONE goes to IDLE on output handshake.
REQ-015 SHALL drive in_ready=1 only in IDLE; accept occurs on a rising edge with in_valid && in_ready.
REQ-016 SHALL, on accept, load lanes into an internal D-entry register file in bit-reversed index order, reducing each lane ≥ Q by one subtraction of Q.
REQ-017 SHALL, in RUN, perform exactly one radix-2 DIT butterfly per cycle: stage s = 0..log2(D)-1, half-span h = 2^s, twiddle W^(j*D/(2h)), u' = (u + t*v) mod Q, v' = (u - t*v) mod Q.
REQ-018 SHALL complete RUN in (D/2)*log2(D) cycles (32 at defaults); out_valid SHALL rise exactly 32 cycles after the accepting edge at defaults.
REQ-019 SHALL hold out_valid and b stable in DONE while out_ready=0.
REQ-020 SHALL return to IDLE on the edge with out_valid && out_ready; in_ready is 1 in the following cycle.
REQ-021 SHALL ignore in_valid in RUN and DONE.
REQ-022 SHALL keep every stored lane and every output lane in [0, Q-1].
REQ-023 SHALL form products at full width 2N bits before modular reduction; at Q=65537, reduction uses 2^16 ≡ -1.
REQ-024 SHALL drive b from the register file; b contents SHALL be undefined outside DONE.

Reset
REQ-025 SHALL, while rst_n=0, immediately force state IDLE, in_ready=1, out_valid=0, and clear all counters.
REQ-026 SHALL, on rst_n assertion mid-RUN or mid-DONE, discard the in-flight transform; the first accept after release SHALL produce a correct result.
REQ-027 SHALL clear the register file on reset; b SHALL read all zeros after reset.

Structure
REQ-028 SHALL place Q, W, D, N, LOGD, the state enumeration and the twiddle-table function (W^k, k = 0..D/2-1) in shared package ntt_pkg.
REQ-029 SHALL instantiate one sub-module, ntt_butterfly: combinational modular multiply, add and subtract, shared with the future pipelined NTT.
REQ-030 SHALL sequence the design with a stage counter and a butterfly counter.

Verification
REQ-031 SHALL cover: lane0=1, others 0 -> all 16 b lanes = 1, out_valid 32 cycles after accept.
REQ-032 SHALL cover: all lanes = 1 -> b0=16, b1..b15=0.
REQ-033 SHALL cover: lane1=1, others 0 -> b[k]=4^k mod 65537: b2=16, b8=65536, b15=49153.
REQ-034 SHALL cover: lane0=65538 (unreduced), others 0 -> all b lanes = 1.
REQ-035 SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_valid and b stable, in_ready=0; then 1-cycle handshake -> in_ready=1 the next cycle.
REQ-036 SHALL cover: rst_n pulsed low at RUN cycle 10 -> out_valid=0 and in_ready=1 immediately; next vector all-ones -> b0=16, others 0.
